// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types, FSM encodings and counter helpers for the branch unit
// Contents:
//   funct3_e              conditional branch condition codes
//   ST_RUN/ST_WAIT_FLUSH  FSM state encodings
//   sat_inc/sat_dec       saturating PHT counter update, width passed as an argument
package branch_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b010,
    BLTU = 3'b011,
    BGE  = 3'b100,
    BGEU = 3'b101
  } funct3_e;

  localparam logic [0:0] ST_RUN        = 1'b0;
  localparam logic [0:0] ST_WAIT_FLUSH = 1'b1;

  // Counters are carried as plain integers so one helper serves any CTR_BITS.
  function automatic int unsigned sat_inc(input int unsigned ctr, input int unsigned bits);
    int unsigned top;
    top = (32'd1 << bits) - 32'd1;
    return (ctr >= top) ? top : ctr + 32'd1;
  endfunction

  function automatic int unsigned sat_dec(input int unsigned ctr);
    return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
  endfunction

endpackage

// File: rtl/branch_result_fifo.sv
// rtl/branch_result_fifo.sv - DEPTH-entry result FIFO between branch S2 and the CDB arbiter
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous clear, wins over push/pop
//   push, push_data   write an entry (accepted when not full, or full with a pop)
//   pop               advance head (ignored while empty)
//   head              oldest entry
//   count, full, empty occupancy status
module branch_result_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop & !empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push & (!full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - two-stage branch/JAL/JALR resolve unit with buffered CDB results
// Ports:
//   issue    : in_valid/in_ready, src1, src2, predicted_pc, target_addr, link_value, in_tag,
//              is_jal, is_jalr, funct3, ctr_state, redirected
//   control  : flush (clears S2 and FIFO, returns FSM to RUN)
//   side     : redirect_valid/redirect_pc, btb_we/btb_target/btb_invalidate, pht_we/pht_next
//   cdb      : cdb_request/cdb_grant, cdb_tag, cdb_result, cdb_taken
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 5,
  parameter int CTR_BITS = 2,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     src1,
  input  logic [XLEN-1:0]     src2,
  input  logic [XLEN-1:0]     predicted_pc,
  input  logic [XLEN-1:0]     target_addr,
  input  logic [XLEN-1:0]     link_value,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic                is_jal,
  input  logic                is_jalr,
  input  logic [2:0]          funct3,
  input  logic [CTR_BITS-1:0] ctr_state,
  input  logic                redirected,
  output logic                redirect_valid,
  output logic [XLEN-1:0]     redirect_pc,
  output logic                btb_we,
  output logic [XLEN-1:0]     btb_target,
  output logic                btb_invalidate,
  output logic                pht_we,
  output logic [CTR_BITS-1:0] pht_next,
  output logic                cdb_request,
  input  logic                cdb_grant,
  output logic [TAG_W-1:0]    cdb_tag,
  output logic [XLEN-1:0]     cdb_result,
  output logic                cdb_taken
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic                is_jal;
    logic                is_jalr;
    logic [CTR_BITS-1:0] ctr_state;
    logic                redirected;
  } br_ctrl_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  result;
    logic             taken;
  } br_result_t;

  // ---------------- S1: resolve in the issue cycle ----------------
  logic [XLEN-1:0] s1_sum;
  logic [XLEN-1:0] s1_correct;
  logic            s1_cond;
  logic            s1_taken;
  logic            accept;

  always_comb begin
    s1_sum  = src1 + src2;
    s1_cond = 1'b1;
    case (funct3)
      BEQ:     s1_cond = (src1 == src2);
      BNE:     s1_cond = (src1 != src2);
      BLT:     s1_cond = ($signed(src1) <  $signed(src2));
      BLTU:    s1_cond = (src1 <  src2);
      BGE:     s1_cond = ($signed(src1) >= $signed(src2));
      BGEU:    s1_cond = (src1 >= src2);
      default: s1_cond = 1'b1;
    endcase
    if (is_jal) begin
      s1_taken   = 1'b1;
      s1_correct = s1_sum;
    end else if (is_jalr) begin
      s1_taken   = 1'b1;
      s1_correct = {s1_sum[XLEN-1:1], 1'b0};
    end else begin
      s1_taken   = s1_cond;
      s1_correct = s1_cond ? target_addr : link_value;
    end
  end

  assign accept = in_valid & in_ready & !flush;

  // ---------------- S2 register ----------------
  logic             s2_valid;
  br_ctrl_t         s2_ctrl;
  logic             s2_taken;
  logic [XLEN-1:0]  s2_correct;
  logic [XLEN-1:0]  s2_target;
  logic [XLEN-1:0]  s2_pred;
  logic [XLEN-1:0]  s2_link;
  logic [TAG_W-1:0] s2_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      s2_ctrl    <= '0;
      s2_taken   <= 1'b0;
      s2_correct <= '0;
      s2_target  <= '0;
      s2_pred    <= '0;
      s2_link    <= '0;
      s2_tag     <= '0;
    end else begin
      s2_valid <= accept;
      if (accept) begin
        s2_ctrl    <= '{is_jal: is_jal, is_jalr: is_jalr & !is_jal,
                        ctr_state: ctr_state, redirected: redirected};
        s2_taken   <= s1_taken;
        s2_correct <= s1_correct;
        s2_target  <= target_addr;
        s2_pred    <= predicted_pc;
        s2_link    <= link_value;
        s2_tag     <= in_tag;
      end
    end
  end

  // ---------------- S2 side-effect pulses ----------------
  logic live;
  logic is_br;
  logic mispredict;
  logic misdirect;
  logic jalr_miss;

  assign live       = s2_valid & !flush;
  assign is_br      = !s2_ctrl.is_jal & !s2_ctrl.is_jalr;
  assign mispredict = s2_ctrl.ctr_state[CTR_BITS-1] ^ s2_taken;
  assign misdirect  = s2_ctrl.redirected & (!s2_taken | (s2_target != s2_pred));
  assign jalr_miss  = !s2_ctrl.redirected | (s2_correct != s2_pred);

  always_comb begin
    redirect_valid = live & (is_br ? (mispredict | misdirect) : (s2_ctrl.is_jalr & jalr_miss));
    redirect_pc    = redirect_valid ? s2_correct : '0;
    btb_we         = live & (is_br ? s2_taken : s2_ctrl.is_jalr);
    btb_target     = '0;
    if (btb_we) btb_target = is_br ? s2_target : s2_correct;
    btb_invalidate = live & is_br & !s2_taken & s2_ctrl.redirected;
    pht_we         = live & is_br;
    pht_next       = '0;
    if (pht_we) begin
      pht_next = s2_taken ? CTR_BITS'(sat_inc(32'(s2_ctrl.ctr_state), CTR_BITS))
                          : CTR_BITS'(sat_dec(32'(s2_ctrl.ctr_state)));
    end
  end

  // ---------------- result FIFO ----------------
  br_result_t       push_data;
  br_result_t       head;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  assign push_data = '{tag: s2_tag, result: is_br ? '0 : s2_link, taken: s2_taken};

  branch_result_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (br_result_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (s2_valid),
    .push_data (push_data),
    .pop       (cdb_grant),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign cdb_request = !fifo_empty;
  assign cdb_tag     = fifo_empty ? '0 : head.tag;
  assign cdb_result  = fifo_empty ? '0 : head.result;
  assign cdb_taken   = !fifo_empty & head.taken;

  // ---------------- FSM ----------------
  logic [0:0] state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              state <= ST_RUN;
    else if (flush)          state <= ST_RUN;
    else if (redirect_valid) state <= ST_WAIT_FLUSH;
  end

  // The instruction in S2 already owns a FIFO slot, so it is counted against DEPTH.
  assign in_ready = (state == ST_RUN) & !redirect_valid & !fifo_full &
                    ((int'(fifo_count) + int'(s2_valid)) < DEPTH);

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - randomized and directed bench for branch_resolve_unit
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src1, src2, predicted_pc, target_addr, link_value;
  logic [4:0]  in_tag;
  logic        is_jal, is_jalr;
  logic [2:0]  funct3;
  logic [1:0]  ctr_state;
  logic [2:0]  ctr_state3;
  logic        redirected;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        btb_we;
  logic [31:0] btb_target;
  logic        btb_invalidate;
  logic        pht_we;
  logic [1:0]  pht_next;
  logic        cdb_request;
  logic        cdb_grant;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_result;
  logic        cdb_taken;

  logic        in_ready_3, redirect_valid_3, btb_we_3, btb_invalidate_3, pht_we_3;
  logic [31:0] redirect_pc_3, btb_target_3, cdb_result_3;
  logic [2:0]  pht_next_3;
  logic        cdb_request_3, cdb_taken_3;
  logic [4:0]  cdb_tag_3;

  branch_resolve_unit #(.XLEN(32), .TAG_W(5), .CTR_BITS(2), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .predicted_pc(predicted_pc), .target_addr(target_addr),
    .link_value(link_value), .in_tag(in_tag), .is_jal(is_jal), .is_jalr(is_jalr),
    .funct3(funct3), .ctr_state(ctr_state), .redirected(redirected),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .btb_we(btb_we),
    .btb_target(btb_target), .btb_invalidate(btb_invalidate), .pht_we(pht_we),
    .pht_next(pht_next), .cdb_request(cdb_request), .cdb_grant(cdb_grant),
    .cdb_tag(cdb_tag), .cdb_result(cdb_result), .cdb_taken(cdb_taken)
  );

  branch_resolve_unit #(.XLEN(32), .TAG_W(5), .CTR_BITS(3), .DEPTH(DEPTH)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_3),
    .src1(src1), .src2(src2), .predicted_pc(predicted_pc), .target_addr(target_addr),
    .link_value(link_value), .in_tag(in_tag), .is_jal(is_jal), .is_jalr(is_jalr),
    .funct3(funct3), .ctr_state(ctr_state3), .redirected(redirected),
    .redirect_valid(redirect_valid_3), .redirect_pc(redirect_pc_3), .btb_we(btb_we_3),
    .btb_target(btb_target_3), .btb_invalidate(btb_invalidate_3), .pht_we(pht_we_3),
    .pht_next(pht_next_3), .cdb_request(cdb_request_3), .cdb_grant(cdb_grant),
    .cdb_tag(cdb_tag_3), .cdb_result(cdb_result_3), .cdb_taken(cdb_taken_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] s1, s2, pred, tgt, link;
    logic [4:0]  tag;
    logic        jal, jalr;
    logic [2:0]  f3;
    logic [1:0]  ctr;
    logic [2:0]  ctr3;
    logic        redir;
  } txn_t;

  typedef struct packed {
    logic        redirect;
    logic [31:0] rpc;
    logic        btb_we;
    logic [31:0] btb_tgt;
    logic        inval;
    logic        pht_we;
    logic [1:0]  pht;
    logic [31:0] result;
    logic        taken;
  } out_t;

  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] result;
    logic        taken;
  } ent_t;

  int   total = 0;
  int   bad   = 0;
  ent_t q[$];
  txn_t pend;
  logic pend_v;
  logic waiting;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int c, input int bits, input logic up);
    int mx;
    mx = (1 << bits) - 1;
    if (up) return (c >= mx) ? mx : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  // What the architecture says should happen for one instruction.
  function automatic out_t resolve(input txn_t t);
    out_t        o;
    logic [31:0] sum, corr;
    logic        tk;
    o   = '0;
    sum = t.s1 + t.s2;
    if (t.jal) begin
      o.taken  = 1'b1;
      o.result = t.link;
    end else if (t.jalr) begin
      corr       = sum & ~32'd1;
      o.taken    = 1'b1;
      o.result   = t.link;
      o.redirect = !t.redir || (corr != t.pred);
      o.rpc      = o.redirect ? corr : 32'd0;
      o.btb_we   = 1'b1;
      o.btb_tgt  = corr;
    end else begin
      case (t.f3)
        3'd0:    tk = (t.s1 == t.s2);
        3'd1:    tk = (t.s1 != t.s2);
        3'd2:    tk = ($signed(t.s1) <  $signed(t.s2));
        3'd3:    tk = (t.s1 <  t.s2);
        3'd4:    tk = ($signed(t.s1) >= $signed(t.s2));
        3'd5:    tk = (t.s1 >= t.s2);
        default: tk = 1'b1;
      endcase
      corr       = tk ? t.tgt : t.link;
      o.taken    = tk;
      o.redirect = (t.ctr[1] != tk) || (t.redir && (!tk || t.tgt != t.pred));
      o.rpc      = o.redirect ? corr : 32'd0;
      o.btb_we   = tk;
      o.btb_tgt  = tk ? t.tgt : 32'd0;
      o.inval    = !tk && t.redir;
      o.pht_we   = 1'b1;
      o.pht      = 2'(sat(int'(t.ctr), 2, tk));
    end
    return o;
  endfunction

  function automatic txn_t mk(input logic jal, input logic jalr, input logic [2:0] f3,
                              input logic [31:0] s1, input logic [31:0] s2,
                              input logic [1:0] ctr, input logic [2:0] ctr3, input logic redir,
                              input logic [31:0] tgt, input logic [31:0] pred,
                              input logic [31:0] link, input logic [4:0] tag);
    txn_t t;
    t.jal = jal; t.jalr = jalr; t.f3 = f3; t.s1 = s1; t.s2 = s2; t.ctr = ctr; t.ctr3 = ctr3;
    t.redir = redir; t.tgt = tgt; t.pred = pred; t.link = link; t.tag = tag;
    return t;
  endfunction

  function automatic txn_t rnd_txn(input logic [4:0] tag);
    txn_t t;
    int   k;
    k      = int'($urandom_range(0, 3));
    t      = '0;
    t.jal  = (k == 0);
    t.jalr = (k == 1);
    t.f3   = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 1) begin
      t.s1 = 32'($urandom_range(0, 6)) - 32'd3;
      t.s2 = 32'($urandom_range(0, 6)) - 32'd3;
    end else begin
      t.s1 = $urandom;
      t.s2 = $urandom;
    end
    t.tgt  = $urandom & 32'hffff_fffc;
    t.link = $urandom & 32'hffff_fffc;
    case ($urandom_range(0, 3))
      0:       t.pred = t.tgt;
      1:       t.pred = (t.s1 + t.s2) & ~32'd1;
      2:       t.pred = t.link;
      default: t.pred = $urandom;
    endcase
    t.ctr   = 2'($urandom_range(0, 3));
    t.ctr3  = 3'($urandom_range(0, 7));
    t.redir = 1'($urandom_range(0, 1));
    t.tag   = tag;
    return t;
  endfunction

  function automatic ent_t head_or_zero();
    ent_t e;
    e = '0;
    if (q.size() > 0) e = q[0];
    return e;
  endfunction

  // One clock: drive at the falling edge, compare against the model, advance the model.
  task automatic step(input logic v, input txn_t t, input logic g, input logic f);
    out_t e;
    ent_t h;
    logic exp_ready;
    logic acc;
    @(negedge clk);
    in_valid = v; src1 = t.s1; src2 = t.s2; predicted_pc = t.pred; target_addr = t.tgt;
    link_value = t.link; in_tag = t.tag; is_jal = t.jal; is_jalr = t.jalr; funct3 = t.f3;
    ctr_state = t.ctr; ctr_state3 = t.ctr3; redirected = t.redir; cdb_grant = g; flush = f;
    #1;
    e = '0;
    if (pend_v && !f) e = resolve(pend);
    exp_ready = !waiting && !e.redirect && ((q.size() + int'(pend_v)) < DEPTH);
    h = head_or_zero();
    check("redirect_valid", 64'(redirect_valid), 64'(e.redirect));
    check("redirect_pc", 64'(redirect_pc), 64'(e.rpc));
    check("btb_we", 64'(btb_we), 64'(e.btb_we));
    check("btb_target", 64'(btb_target), 64'(e.btb_tgt));
    check("btb_invalidate", 64'(btb_invalidate), 64'(e.inval));
    check("pht_we", 64'(pht_we), 64'(e.pht_we));
    check("pht_next", 64'(pht_next), 64'(e.pht));
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    check("cdb_request", 64'(cdb_request), 64'(q.size() > 0));
    check("cdb_tag", 64'(cdb_tag), 64'(h.tag));
    check("cdb_result", 64'(cdb_result), 64'(h.result));
    check("cdb_taken", 64'(cdb_taken), 64'(h.taken));
    acc = v && exp_ready && !f;
    if (f) begin
      q.delete();
      pend_v  = 1'b0;
      waiting = 1'b0;
    end else begin
      if (g && q.size() > 0) void'(q.pop_front());
      if (pend_v) q.push_back('{tag: pend.tag, result: e.result, taken: e.taken});
      if (e.redirect) waiting = 1'b1;
      pend_v = acc;
    end
    if (acc) pend = t;
  endtask

  txn_t idle;
  txn_t t;
  logic [4:0] tagc;

  initial begin
    idle = '0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; cdb_grant = 1'b0;
    src1 = '0; src2 = '0; predicted_pc = '0; target_addr = '0; link_value = '0;
    in_tag = '0; is_jal = 1'b0; is_jalr = 1'b0; funct3 = '0; ctr_state = '0;
    ctr_state3 = '0; redirected = 1'b0;
    pend = '0; pend_v = 1'b0; waiting = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_cdb_request", 64'(cdb_request), 64'd0);
    check("rst_redirect", 64'(redirect_valid), 64'd0);
    check("rst_pht_we", 64'(pht_we), 64'd0);
    rst_n = 1'b1;

    // BLT -1 < 1, predicted taken, BTB target correct
    step(1'b1, mk(0, 0, 3'd2, 32'hffff_ffff, 32'd1, 2'b10, 3'd0, 1, 32'h100, 32'h100, 32'h104, 5'd1),
         1'b0, 1'b0);
    step(1'b0, idle, 1'b0, 1'b0);
    check("blt_redirect", 64'(redirect_valid), 64'd0);
    check("blt_pht_next", 64'(pht_next), 64'b11);
    check("blt_btb_we", 64'(btb_we), 64'd1);
    step(1'b0, idle, 1'b0, 1'b0);
    check("blt_cdb_request", 64'(cdb_request), 64'd1);
    check("blt_cdb_taken", 64'(cdb_taken), 64'd1);
    step(1'b0, idle, 1'b1, 1'b0);

    // BEQ 5 vs 6 with strong-taken counter: mispredict, BTB invalidate
    step(1'b1, mk(0, 0, 3'd0, 32'd5, 32'd6, 2'b11, 3'd0, 1, 32'h300, 32'h300, 32'h204, 5'd2),
         1'b0, 1'b0);
    step(1'b0, idle, 1'b0, 1'b0);
    check("beq_redirect", 64'(redirect_valid), 64'd1);
    check("beq_redirect_pc", 64'(redirect_pc), 64'h204);
    check("beq_invalidate", 64'(btb_invalidate), 64'd1);
    check("beq_pht_next", 64'(pht_next), 64'b10);
    step(1'b1, idle, 1'b1, 1'b0);
    check("beq_wait_ready", 64'(in_ready), 64'd0);
    step(1'b1, idle, 1'b0, 1'b0);
    step(1'b0, idle, 1'b0, 1'b1);

    // JALR 0x1003 + 0 -> 0x1002, fetch predicted 0x1000
    step(1'b1, mk(0, 1, 3'd0, 32'h1003, 32'd0, 2'b00, 3'd0, 1, 32'h0, 32'h1000, 32'h2000, 5'd3),
         1'b0, 1'b0);
    step(1'b0, idle, 1'b0, 1'b0);
    check("jalr_redirect", 64'(redirect_valid), 64'd1);
    check("jalr_redirect_pc", 64'(redirect_pc), 64'h1002);
    check("jalr_btb_target", 64'(btb_target), 64'h1002);
    step(1'b0, idle, 1'b0, 1'b0);
    check("jalr_cdb_result", 64'(cdb_result), 64'h2000);
    step(1'b0, idle, 1'b0, 1'b1);

    // 3-bit counters: 111 taken, 000 not taken, 011 taken
    step(1'b1, mk(0, 0, 3'd0, 32'd1, 32'd1, 2'b11, 3'b111, 0, 32'h40, 32'h0, 32'h44, 5'd4),
         1'b0, 1'b0);
    step(1'b1, mk(0, 0, 3'd0, 32'd1, 32'd2, 2'b00, 3'b000, 0, 32'h40, 32'h0, 32'h44, 5'd5),
         1'b0, 1'b0);
    check("ctr3_sat_hi", 64'(pht_next_3), 64'b111);
    step(1'b1, mk(0, 0, 3'd0, 32'd1, 32'd1, 2'b01, 3'b011, 0, 32'h40, 32'h0, 32'h44, 5'd6),
         1'b0, 1'b0);
    check("ctr3_sat_lo", 64'(pht_next_3), 64'b000);
    step(1'b0, idle, 1'b0, 1'b0);
    check("ctr3_inc", 64'(pht_next_3), 64'b100);
    step(1'b0, idle, 1'b0, 1'b1);

    // Four JALs with no grant fill the unit; one grant frees a slot
    for (int i = 0; i < 4; i++)
      step(1'b1, mk(1, 0, 3'd0, 32'h10, 32'h4, 2'b00, 3'd0, 0, 32'h0, 32'h14, 32'h80 + 32'(i), 5'(8 + i)),
           1'b0, 1'b0);
    step(1'b0, idle, 1'b0, 1'b0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    step(1'b0, idle, 1'b1, 1'b0);
    step(1'b0, idle, 1'b0, 1'b0);
    check("after_grant_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, idle, 1'b1, 1'b0);
      check("fifo_order", 64'(cdb_tag), 64'(9 + i));
    end

    // Three buffered results plus a mispredicting branch in S2, then flush
    for (int i = 0; i < 3; i++)
      step(1'b1, mk(1, 0, 3'd0, 32'h10, 32'h4, 2'b00, 3'd0, 0, 32'h0, 32'h14, 32'h90, 5'(16 + i)),
           1'b0, 1'b0);
    step(1'b1, mk(0, 0, 3'd0, 32'd5, 32'd6, 2'b11, 3'd0, 1, 32'h300, 32'h300, 32'h204, 5'd19),
         1'b0, 1'b0);
    step(1'b1, mk(1, 0, 3'd0, 32'h10, 32'h4, 2'b00, 3'd0, 0, 32'h0, 32'h14, 32'h90, 5'd20),
         1'b0, 1'b1);
    check("flush_no_redirect", 64'(redirect_valid), 64'd0);
    check("flush_no_pht", 64'(pht_we), 64'd0);
    check("flush_no_btb", 64'({btb_we, btb_invalidate}), 64'd0);
    step(1'b0, idle, 1'b0, 1'b0);
    check("flush_cdb_request", 64'(cdb_request), 64'd0);
    check("flush_no_s2", 64'(redirect_valid | pht_we | btb_we), 64'd0);

    // Randomized traffic
    tagc = 5'd0;
    for (int n = 0; n < 3000; n++) begin
      t = rnd_txn(tagc);
      step(1'($urandom_range(0, 1)), t, 1'($urandom_range(0, 1)),
           waiting ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0));
      if (pend_v && pend.tag == tagc) tagc = tagc + 5'd1;
    end

    // Asynchronous reset in the middle of traffic
    step(1'b1, mk(0, 0, 3'd0, 32'd5, 32'd6, 2'b11, 3'd0, 1, 32'h300, 32'h300, 32'h204, 5'd7),
         1'b0, 1'b0);
    step(1'b0, idle, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_redirect", 64'(redirect_valid), 64'd0);
    check("arst_cdb_request", 64'(cdb_request), 64'd0);
    check("arst_side", 64'({btb_we, btb_invalidate, pht_we, pht_next}), 64'd0);
    check("arst_cdb_fields", 64'({cdb_tag, cdb_taken}) | 64'(cdb_result) | 64'(redirect_pc), 64'd0);
    q.delete(); pend_v = 1'b0; waiting = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 200; n++) begin
      t = rnd_txn(5'(n));
      step(1'($urandom_range(0, 1)), t, 1'($urandom_range(0, 1)),
           waiting ? ($urandom_range(0, 3) == 0) : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Pipelined, parametrised branch functional unit. Resolves conditional branches, JAL and JALR.
- Generalises the counter width and adds JALR target prediction checking.
- Registers redirect, BTB and PHT updates; buffers results in a DEPTH-entry FIFO until the common-data-bus arbiter grants.
- Sits between the branch reservation station (valid/ready issue) and the CDB round-robin arbiter (request/grant).

Parameters:
XLEN, 32, datapath/address width
TAG_W, 5, ROB tag width
CTR_BITS, 2, PHT saturating counter width (>=2); prediction = MSB
DEPTH, 4, result FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  pipeline flush from commit/redirect logic
in_valid  in  1  issue valid
in_ready  out  1  unit can accept issue this cycle
src1, src2  in  XLEN  operands (JAL/JALR: base and offset)
predicted_pc  in  XLEN  fetch's predicted next PC
target_addr  in  XLEN  branch target (PC+imm)
link_value  in  XLEN  PC+4 for JAL/JALR, written to CDB
in_tag  in  TAG_W  ROB tag
is_jal, is_jalr  in  1  instruction kind (both 0 = conditional branch)
funct3  in  3  000 BEQ, 001 BNE, 010 BLT, 011 BLTU, 100 BGE, 101 BGEU, other = always taken
ctr_state  in  CTR_BITS  PHT counter read at fetch
redirected  in  1  BTB hit redirected fetch
redirect_valid  out  1  one-cycle pulse: flush front end
redirect_pc  out  XLEN  correct next PC
btb_we  out  1  BTB write enable
btb_target  out  XLEN  target to write
btb_invalidate  out  1  clear BTB entry (predicted taken, not taken)
pht_we  out  1  PHT update enable
pht_next  out  CTR_BITS  updated counter
cdb_request  out  1  FIFO non-empty
cdb_grant  in  1  arbiter grant; pops head
cdb_tag  out  TAG_W  head tag
cdb_result  out  XLEN  head link_value (0 for branches)
cdb_taken  out  1  head resolved direction

Behaviour:
- Reset (rst_n low, async): FIFO empty, stage register invalid, FSM = RUN; all outputs 0 except in_ready = 1.
- Stage S1 (issue cycle, combinational):
  - sum = src1 + src2 (XLEN, wraps).
  - Branch: taken per funct3 (signed vs unsigned compare), correct = taken ? target_addr : link_value.
  - JAL: correct = sum, taken = 1.
  - JALR: correct = {sum[XLEN-1:1], 0}, taken = 1.
- S2 register (1 cycle later): all side outputs are registered pulses driven from S2.
- Branch in S2:
  - mispredict = ctr_state[MSB] ^ taken.
  - misdirect = redirected & (!taken | target_addr != predicted_pc).
  - redirect_valid = mispredict | misdirect.
  - pht_we = 1; pht_next = taken ? sat_inc(ctr_state) : sat_dec(ctr_state). Saturates at all-ones and 0.
  - btb_we = taken (btb_target = target_addr); btb_invalidate = !taken & redirected.
- JAL in S2: no redirect, btb_we = 0, pht_we = 0.
- JALR in S2:
  - redirect_valid = !redirected | (correct != predicted_pc).
  - btb_we = 1, btb_target = correct; pht_we = 0.
- S2 pushes {tag, result, taken} into FIFO for every instruction kind.
- FSM:
  - RUN: on redirect_valid -> WAIT_FLUSH.
  - WAIT_FLUSH: in_ready = 0; drains FIFO normally; flush -> RUN.
  - flush in RUN stays RUN.
- in_ready = (state == RUN) & !redirect_valid & (fifo_count + s2_valid < DEPTH).
- Accept = in_valid & in_ready; in_valid while !in_ready is ignored (holder retains).
- Simultaneous push and pop at full-1 or full: legal, count unchanged.
- cdb_grant while empty: ignored. cdb_grant is sampled the cycle cdb_request is high; head advances the next cycle.
- flush (synchronous effect, priority over all):
  - clears S2 valid and the FIFO; suppresses that cycle's redirect/btb/pht pulses; drops the same-cycle issue.
  - FSM -> RUN.
- Pointers wrap modulo DEPTH; count width = clog2(DEPTH)+1.

Decomposition:
- Package branch_pkg:
  - funct3 enum (BEQ..BGEU).
  - typedef br_ctrl_t {is_jal, is_jalr, funct3, ctr_state, redirected}.
  - typedef br_result_t {tag, result, taken}.
  - FSM enum {RUN, WAIT_FLUSH}.
  - functions sat_inc/sat_dec parametrised on CTR_BITS.
- One sub-module: branch_result_fifo, a generic DEPTH x br_result_t FIFO with push/pop/flush, count, and full/empty.

Test Plan:
- BLT src1=-1, src2=1, ctr=10 (CTR_BITS=2), redirected=1, target=predicted=0x100.
  - Next cycle: redirect_valid=0, pht_next=11, btb_we=1.
  - cdb_request=1, cdb_taken=1.
- BEQ 5 vs 6, ctr=11, redirected=1.
  - redirect_valid=1, redirect_pc=link_value, btb_invalidate=1, pht_next=10.
  - in_ready=0 until flush.
- JALR src1=0x1003, src2=0, predicted=0x1000, redirected=1.
  - correct=0x1002, redirect_valid=1, btb_target=0x1002.
  - cdb_result=link_value.
- CTR_BITS=3: ctr 111 taken -> 111; ctr 000 not-taken -> 000; ctr 011 taken -> 100.
- Hold cdb_grant=0, issue 4 correctly predicted JALs.
  - in_ready falls after the 4th accept.
  - Grant 1 cycle -> in_ready returns; FIFO order by tag preserved.
- Fill 3 entries, assert flush with in_valid=1 and a mispredicting branch in S2.
  - cdb_request=0 next cycle, no redirect/btb/pht pulse.
  - Mid-operation rst_n low -> all outputs 0 immediately, in_ready=1.
